// File: rtl/axil_slv_pkg.sv
// Shared types and helpers for the AXI4-Lite register-file responder.
package axil_slv_pkg;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_COMMIT,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_slv_rd_chan.sv
// AR/R channel: rdata registered one cycle after the AR handshake, held until rready;
// arready drops while a beat is pending so at most one read is outstanding.
module axil_slv_rd_chan
  import axil_slv_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] OOR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                     axi_aclk,
  input  logic                     axi_areset,
  input  logic                     rd_en,
  input  logic                     axi_arvalid,
  output logic                     axi_arready,
  input  logic [ADDR_W-1:0]        axi_araddr,
  output logic                     axi_rvalid,
  input  logic                     axi_rready,
  output logic [31:0]              axi_rdata,
  input  logic [NUM_REGS*32-1:0]   reg_view
);

  localparam int IDX_W = ADDR_W - 2;

  rd_state_e          rd_state;
  logic [IDX_W-1:0]   ar_idx;
  logic [31:0]        rd_word;
  logic               unused_ar_lsb;

  assign ar_idx        = axi_araddr[ADDR_W-1:2];
  assign unused_ar_lsb = ^axi_araddr[1:0];
  assign axi_arready   = rd_en && (rd_state == RD_IDLE);

  // Indices past the last register fall through to the out-of-range pattern.
  always_comb begin
    rd_word = OOR_RDATA;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_word = reg_view[32*i +: 32];
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      rd_state   <= RD_IDLE;
      axi_rvalid <= 1'b0;
      axi_rdata  <= 32'h0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (axi_arvalid && axi_arready) begin
            axi_rdata  <= rd_word;
            axi_rvalid <= 1'b1;
            rd_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            rd_state   <= RD_IDLE;
          end
        end
        default: begin
          axi_rvalid <= 1'b0;
          rd_state   <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite register file: AW/W accepted in any order, commit one cycle after both, pulse the cycle after.
// Define AXIL_SLV_BCHAN_EN to add the B channel; the write FSM then holds in WR_RESP until bready.
module axi_lite_slave_regfile
  import axil_slv_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] RST_VAL   = 32'h0,
  parameter logic [31:0] OOR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                     axi_aclk,
  input  logic                     axi_areset,
  input  logic                     axi_awvalid,
  output logic                     axi_awready,
  input  logic [ADDR_W-1:0]        axi_awaddr,
  input  logic                     axi_wvalid,
  output logic                     axi_wready,
  input  logic [31:0]              axi_wdata,
  input  logic [3:0]               axi_wstrb,
  input  logic                     axi_arvalid,
  output logic                     axi_arready,
  input  logic [ADDR_W-1:0]        axi_araddr,
  output logic                     axi_rvalid,
  input  logic                     axi_rready,
  output logic [31:0]              axi_rdata,
`ifdef AXIL_SLV_BCHAN_EN
  output logic                     axi_bvalid,
  input  logic                     axi_bready,
  output logic [1:0]               axi_bresp,
`endif
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = ADDR_W - 2;

  wr_state_e          wr_state;
  logic               init_q;
  logic [IDX_W-1:0]   aw_idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic               aw_hs;
  logic               w_hs;
  logic               commit;
  logic [NUM_REGS-1:0] hit;
  logic [31:0]        regs [NUM_REGS];
  logic               unused_aw_lsb;

  assign unused_aw_lsb = ^axi_awaddr[1:0];

  // Readys stay low through the first edge after reset release.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) init_q <= 1'b0;
    else            init_q <= 1'b1;
  end

  assign axi_awready = init_q && (wr_state == WR_IDLE || wr_state == WR_HAVE_W);
  assign axi_wready  = init_q && (wr_state == WR_IDLE || wr_state == WR_HAVE_AW);
  assign aw_hs       = axi_awvalid && axi_awready;
  assign w_hs        = axi_wvalid && axi_wready;
  assign commit      = (wr_state == WR_COMMIT);

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_state     <= WR_IDLE;
      aw_idx_q     <= '0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      reg_wr_pulse <= '0;
`ifdef AXIL_SLV_BCHAN_EN
      axi_bvalid   <= 1'b0;
      axi_bresp    <= BRESP_OKAY;
`endif
    end else begin
      reg_wr_pulse <= commit ? hit : '0;
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) aw_idx_q <= axi_awaddr[ADDR_W-1:2];
          if (w_hs) begin
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
          end
          if (aw_hs && w_hs) wr_state <= WR_COMMIT;
          else if (aw_hs)    wr_state <= WR_HAVE_AW;
          else if (w_hs)     wr_state <= WR_HAVE_W;
        end
        WR_HAVE_AW: begin
          if (w_hs) begin
            wdata_q  <= axi_wdata;
            wstrb_q  <= axi_wstrb;
            wr_state <= WR_COMMIT;
          end
        end
        WR_HAVE_W: begin
          if (aw_hs) begin
            aw_idx_q <= axi_awaddr[ADDR_W-1:2];
            wr_state <= WR_COMMIT;
          end
        end
        WR_COMMIT: begin
`ifdef AXIL_SLV_BCHAN_EN
          axi_bvalid <= 1'b1;
          axi_bresp  <= (|hit) ? BRESP_OKAY : BRESP_SLVERR;
          wr_state   <= WR_RESP;
`else
          wr_state   <= WR_IDLE;
`endif
        end
`ifdef AXIL_SLV_BCHAN_EN
        WR_RESP: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            wr_state   <= WR_IDLE;
          end
        end
`endif
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // An index with no matching register leaves hit all-zero, so the write drops out.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    assign hit[g] = (aw_idx_q == IDX_W'(g));

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset)          regs[g] <= RST_VAL;
      else if (commit && hit[g]) regs[g] <= strb_merge(regs[g], wdata_q, wstrb_q);
    end

    assign reg_out[32*g +: 32] = regs[g];
  end

  axil_slv_rd_chan #(
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .OOR_RDATA (OOR_RDATA)
  ) u_rd_chan (
    .axi_aclk    (axi_aclk),
    .axi_areset  (axi_areset),
    .rd_en       (init_q),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_araddr  (axi_araddr),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rdata   (axi_rdata),
    .reg_view    (reg_out)
  );

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed bench for axi_lite_slave_regfile with hand-computed register expectations.
module tb_axi_lite_slave_regfile;

  localparam int ADDR_W   = 12;
  localparam int NUM_REGS = 16;

  logic                    axi_aclk    = 1'b0;
  logic                    axi_areset  = 1'b1;
  logic                    axi_awvalid = 1'b0;
  logic                    axi_awready;
  logic [ADDR_W-1:0]       axi_awaddr  = '0;
  logic                    axi_wvalid  = 1'b0;
  logic                    axi_wready;
  logic [31:0]             axi_wdata   = '0;
  logic [3:0]              axi_wstrb   = '0;
  logic                    axi_arvalid = 1'b0;
  logic                    axi_arready;
  logic [ADDR_W-1:0]       axi_araddr  = '0;
  logic                    axi_rvalid;
  logic                    axi_rready  = 1'b0;
  logic [31:0]             axi_rdata;
`ifdef AXIL_SLV_BCHAN_EN
  logic                    axi_bvalid;
  logic                    axi_bready  = 1'b1;
  logic [1:0]              axi_bresp;
`endif
  logic [NUM_REGS*32-1:0]  reg_out;
  logic [NUM_REGS-1:0]     reg_wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] m [NUM_REGS];

  always #5 axi_aclk = ~axi_aclk;

  axi_lite_slave_regfile dut (
    .axi_aclk     (axi_aclk),
    .axi_areset   (axi_areset),
    .axi_awvalid  (axi_awvalid),
    .axi_awready  (axi_awready),
    .axi_awaddr   (axi_awaddr),
    .axi_wvalid   (axi_wvalid),
    .axi_wready   (axi_wready),
    .axi_wdata    (axi_wdata),
    .axi_wstrb    (axi_wstrb),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_araddr   (axi_araddr),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .axi_rdata    (axi_rdata),
`ifdef AXIL_SLV_BCHAN_EN
    .axi_bvalid   (axi_bvalid),
    .axi_bready   (axi_bready),
    .axi_bresp    (axi_bresp),
`endif
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_REGS*32-1:0] model_flat();
    logic [NUM_REGS*32-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = m[i];
    return f;
  endfunction

  task automatic aw_beat(input logic [ADDR_W-1:0] a);
    int n;
    @(negedge axi_aclk);
    axi_awvalid = 1'b1;
    axi_awaddr  = a;
    n = 0;
    while (!axi_awready && n < 20) begin @(negedge axi_aclk); n++; end
    check("aw_ready_wait", axi_awready, 1'b1);
    @(posedge axi_aclk);
    #1 axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge axi_aclk);
    axi_wvalid = 1'b1;
    axi_wdata  = d;
    axi_wstrb  = s;
    n = 0;
    while (!axi_wready && n < 20) begin @(negedge axi_aclk); n++; end
    check("w_ready_wait", axi_wready, 1'b1);
    @(posedge axi_aclk);
    #1 axi_wvalid = 1'b0;
  endtask

  task automatic aw_w_beat(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge axi_aclk);
    axi_awvalid = 1'b1;
    axi_awaddr  = a;
    axi_wvalid  = 1'b1;
    axi_wdata   = d;
    axi_wstrb   = s;
    n = 0;
    while (!(axi_awready && axi_wready) && n < 20) begin @(negedge axi_aclk); n++; end
    check("aw_w_ready_wait", {axi_awready, axi_wready}, 2'b11);
    @(posedge axi_aclk);
    #1;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
  endtask

  task automatic ar_beat(input logic [ADDR_W-1:0] a);
    int n;
    @(negedge axi_aclk);
    axi_arvalid = 1'b1;
    axi_araddr  = a;
    n = 0;
    while (!axi_arready && n < 20) begin @(negedge axi_aclk); n++; end
    check("ar_ready_wait", axi_arready, 1'b1);
    @(posedge axi_aclk);
    #1 axi_arvalid = 1'b0;
  endtask

  // Called right after the edge that completed both beats; m already holds the post-write image.
  task automatic commit_check(input string tag, input logic [NUM_REGS-1:0] exp_pulse);
    @(negedge axi_aclk);
    check({tag, "_commit_rdy"}, {axi_awready, axi_wready}, 2'b00);
    check({tag, "_commit_nopulse"}, reg_wr_pulse, '0);
    @(negedge axi_aclk);
    check({tag, "_regs"}, reg_out, model_flat());
    check({tag, "_pulse"}, reg_wr_pulse, exp_pulse);
`ifdef AXIL_SLV_BCHAN_EN
    check({tag, "_bresp"}, {axi_bvalid, axi_bresp}, {1'b1, (exp_pulse == '0) ? 2'b10 : 2'b00});
`else
    check({tag, "_idle_rdy"}, {axi_awready, axi_wready}, 2'b11);
`endif
    @(negedge axi_aclk);
    check({tag, "_pulse_end"}, reg_wr_pulse, '0);
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp, input int hold);
    ar_beat(a);
    @(negedge axi_aclk);
    check({tag, "_rvalid"}, axi_rvalid, 1'b1);
    check({tag, "_rdata"}, axi_rdata, exp);
    check({tag, "_arready_busy"}, axi_arready, 1'b0);
    for (int i = 1; i < hold; i++) begin
      @(negedge axi_aclk);
      check({tag, "_hold"}, {axi_rvalid, axi_arready, axi_rdata}, {1'b1, 1'b0, exp});
    end
    axi_rready = 1'b1;
    @(posedge axi_aclk);
    #1 axi_rready = 1'b0;
    @(negedge axi_aclk);
    check({tag, "_done"}, {axi_rvalid, axi_arready, axi_rdata}, {1'b0, 1'b1, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) m[i] = 32'h0;

    // Reset release and ready gating
    repeat (3) @(negedge axi_aclk);
    axi_areset = 1'b0;
    #1;
    check("rst_readys", {axi_awready, axi_wready, axi_arready}, 3'b000);
    check("rst_r", {axi_rvalid, axi_rdata}, 33'h0);
    check("rst_pulse", reg_wr_pulse, '0);
    @(negedge axi_aclk);
    check("init_readys", {axi_awready, axi_wready, axi_arready}, 3'b111);
    check("rst_regs", reg_out, model_flat());

    // AW first, W three cycles later
    aw_beat(12'h008);
    @(negedge axi_aclk);
    check("have_aw_rdy", {axi_awready, axi_wready}, 2'b01);
    @(negedge axi_aclk);
    w_beat(32'hA5A5_1234, 4'hF);
    m[2] = 32'hA5A5_1234;
    commit_check("wr_aw_first", 16'h0004);

    // W first, partial strobe
    w_beat(32'hFFFF_FFFF, 4'b0101);
    @(negedge axi_aclk);
    check("have_w_rdy", {axi_awready, axi_wready}, 2'b10);
    aw_beat(12'h00C);
    m[3] = 32'h00FF_00FF;
    commit_check("wr_w_first", 16'h0008);

    // Zero strobe still pulses
    aw_w_beat(12'h010, 32'hFFFF_FFFF, 4'h0);
    commit_check("wr_strb0", 16'h0010);

    // Read with rready low for four cycles
    rd("rd_hold", 12'h008, 32'hA5A5_1234, 4);

    // Early rready, unaligned address to reg 3
    axi_rready = 1'b1;
    ar_beat(12'h00F);
    @(negedge axi_aclk);
    check("rd_early_rdata", {axi_rvalid, axi_rdata}, {1'b1, 32'h00FF_00FF});
    @(negedge axi_aclk);
    check("rd_early_done", {axi_rvalid, axi_arready}, 2'b01);
    axi_rready = 1'b0;

    // Out-of-range read and write
    rd("rd_oor", 12'h100, 32'hDEAD_BEEF, 1);
    aw_w_beat(12'h100, 32'h1234_5678, 4'hF);
    commit_check("wr_oor", 16'h0000);

    // AR handshake on the commit edge sees the old value
    aw_w_beat(12'h004, 32'h1111_1111, 4'hF);
    ar_beat(12'h004);
    m[1] = 32'h1111_1111;
    @(negedge axi_aclk);
    check("rd_collide_rdata", {axi_rvalid, axi_rdata}, {1'b1, 32'h0});
    check("rd_collide_reg", reg_out, model_flat());
    check("rd_collide_pulse", reg_wr_pulse, 16'h0002);
    axi_rready = 1'b1;
    @(posedge axi_aclk);
    #1 axi_rready = 1'b0;
    rd("rd_after_collide", 12'h004, 32'h1111_1111, 1);

    // Reset with an AW beat in flight
    aw_beat(12'h014);
    @(negedge axi_aclk);
    axi_areset = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) m[i] = 32'h0;
    @(negedge axi_aclk);
    check("mid_rst_readys", {axi_awready, axi_wready, axi_arready}, 3'b000);
    check("mid_rst_rdata", axi_rdata, 32'h0);
    check("mid_rst_regs", reg_out, model_flat());
    axi_areset = 1'b0;
    @(negedge axi_aclk);
    check("mid_rst_init", {axi_awready, axi_wready, axi_arready}, 3'b111);
    w_beat(32'h0000_5555, 4'hF);
    @(negedge axi_aclk);
    check("mid_rst_aw_lost", {axi_awready, axi_wready}, 2'b10);
    check("mid_rst_nopulse", reg_wr_pulse, '0);
    aw_beat(12'h014);
    m[5] = 32'h0000_5555;
    commit_check("wr_after_rst", 16'h0020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
